// File: rtl/timer_cmp_pkg.sv
// Shared types and helpers for the multi-channel alarm comparator.
// Channel state encoding, field slicing and ring counter sizing live here.
package timer_cmp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_RINGING,
      ST_DONE
   } chState_t;

   // LSB of channel ch's field inside a packed per-channel bus
   function automatic int fieldLsb(input int ch, input int dw);
      return ch * dw;
   endfunction

   // Ring counter must hold 0..RING_TICKS-1; never narrower than one bit
   function automatic int ringCntW(input int ticks);
      return (ticks < 1) ? 1 : $clog2(ticks + 1);
   endfunction

endpackage

// File: rtl/timer_cmp_ch.sv
// One alarm channel: time comparator, edge-detect register, arm/ring FSM
// and ring-length counter.
module timer_cmp_ch
   import timer_cmp_pkg::*;
#(
   parameter int DW         = 8,
   parameter int RING_TICKS = 10
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          en,
   input  logic          tick,
   input  logic [DW-1:0] countH,
   input  logic [DW-1:0] countM,
   input  logic [DW-1:0] countS,
   input  logic [DW-1:0] progH,
   input  logic [DW-1:0] progM,
   input  logic [DW-1:0] progS,
   input  logic          arm,
   input  logic          repeatMd,
   input  logic          ack,
   output logic          fin,
   output logic          armed,
   output logic          finNext
);

   localparam int            CW       = ringCntW(RING_TICKS);
   localparam bit            TICK_END = (RING_TICKS != 0);
   localparam logic [CW-1:0] LAST_CNT = TICK_END ? CW'(RING_TICKS - 1) : '0;

   chState_t      state, stateNext;
   logic [CW-1:0] cntQ, cntNext;
   logic          match, matchQ, rise, ringEnd;

   always_comb begin
      match   = en && (progH == countH) && (progM == countM) && (progS == countS)
                && (|{progH, progM, progS});
      rise    = match && !matchQ;
      ringEnd = ack || (TICK_END && tick && (cntQ == LAST_CNT));
   end

   always_comb begin
      stateNext = state;
      cntNext   = cntQ;
      if (!arm) begin
         stateNext = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  stateNext = ST_ARMED;
            ST_ARMED: begin
               if (rise) begin
                  stateNext = ST_RINGING;
                  cntNext   = '0;
               end
            end
            ST_RINGING: begin
               // en/rise/prog are deliberately ignored once ringing
               if (ringEnd) begin
                  stateNext = repeatMd ? ST_ARMED : ST_DONE;
               end else if (tick && TICK_END) begin
                  cntNext = cntQ + CW'(1);
               end
            end
            ST_DONE:  stateNext = ST_DONE;
            default:  stateNext = ST_IDLE;
         endcase
      end
   end

   assign finNext = (stateNext == ST_RINGING);

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= ST_IDLE;
         matchQ <= 1'b0;
         cntQ   <= '0;
         fin    <= 1'b0;
         armed  <= 1'b0;
      end else begin
         state  <= stateNext;
         matchQ <= match;
         cntQ   <= cntNext;
         fin    <= finNext;
         armed  <= (stateNext == ST_ARMED);
      end
   end

endmodule

// File: rtl/timer_alarm_cmp.sv
// Multi-channel alarm comparator: N_CH independent channels sharing one
// running BCD time, plus a registered OR of all ring outputs.
module timer_alarm_cmp
   import timer_cmp_pkg::*;
#(
   parameter int N_CH       = 2,
   parameter int DW         = 8,
   parameter int RING_TICKS = 10
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               en,
   input  logic               tick,
   input  logic [DW-1:0]      count_h,
   input  logic [DW-1:0]      count_m,
   input  logic [DW-1:0]      count_s,
   input  logic [N_CH*DW-1:0] prog_h,
   input  logic [N_CH*DW-1:0] prog_m,
   input  logic [N_CH*DW-1:0] prog_s,
   input  logic [N_CH-1:0]    arm,
   input  logic [N_CH-1:0]    repeat_md,
   input  logic [N_CH-1:0]    ack,
   output logic [N_CH-1:0]    fin,
   output logic               any_fin,
   output logic [N_CH-1:0]    armed
);

   logic [N_CH-1:0] finNext;

   for (genvar i = 0; i < N_CH; i++) begin : gCh
      timer_cmp_ch #(
         .DW         (DW),
         .RING_TICKS (RING_TICKS)
      ) uCh (
         .clock    (clock),
         .reset    (reset),
         .en       (en),
         .tick     (tick),
         .countH   (count_h),
         .countM   (count_m),
         .countS   (count_s),
         .progH    (prog_h[fieldLsb(i, DW) +: DW]),
         .progM    (prog_m[fieldLsb(i, DW) +: DW]),
         .progS    (prog_s[fieldLsb(i, DW) +: DW]),
         .arm      (arm[i]),
         .repeatMd (repeat_md[i]),
         .ack      (ack[i]),
         .fin      (fin[i]),
         .armed    (armed[i]),
         .finNext  (finNext[i])
      );
   end

   // Built from next-state so it lands on the same edge as fin
   always_ff @(posedge clock) begin
      if (reset) begin
         any_fin <= 1'b0;
      end else begin
         any_fin <= |finNext;
      end
   end

endmodule

// File: doc/timer_alarm_cmp.md
# timer_alarm_cmp

Multi-channel alarm comparator for the clock/timer datapath. It compares one shared running time (BCD hours/minutes/seconds) against N_CH independently programmed alarm times. Each channel has its own arm/ack handshake and one-shot or repeat mode. A matched channel asserts `fin` for a bounded ring period, counted in 1 s ticks.

## Interface
Parameters:
- `N_CH`, default 2: number of alarm channels (1..8).
- `DW`, default 8: width of each time field (two BCD digits).
- `RING_TICKS`, default 10: ring length in `tick` pulses. 0 means ring until `ack` or disarm.

Ports (one clock; reset is synchronous and active-high):
- `clock`: input, 1. Sole clock.
- `reset`: input, 1. Synchronous, active-high.
- `en`: input, 1. Comparison enable.
- `tick`: input, 1. One-cycle 1 s strobe.
- `count_h`, `count_m`, `count_s`: input, DW each. Running time, shared by all channels.
- `prog_h`, `prog_m`, `prog_s`: input, N_CH*DW each. Programmed times; channel i occupies bits [i*DW +: DW].
- `arm`: input, N_CH. Level; channel i is armed while `arm[i]`=1.
- `repeat_md`: input, N_CH. 1 means re-arm automatically after the ring ends.
- `ack`: input, N_CH. Single-cycle acknowledge; stops the ring.
- `fin`: output, N_CH, registered. High while channel i is ringing.
- `any_fin`: output, 1, registered. OR of `fin`.
- `armed`: output, N_CH, registered. High in state ARMED.

## Operation
- Per-channel states: IDLE, ARMED, RINGING, DONE.
- `match[i]` (combinational) is true when all three prog fields equal the count fields, `en`=1, and the prog time is non-zero. All-zero prog never matches.
- `match_q[i]` is a register. When `en`=1 it loads `match[i]`; when `en`=0 it is cleared.
- `rise[i]` = `match[i]` & ~`match_q[i]`. A trigger fires once per entry into equality.
- Transitions, highest priority first:
  - Any state with `arm[i]`=0 goes to IDLE.
  - IDLE with `arm[i]`=1 goes to ARMED.
  - ARMED with `rise[i]` goes to RINGING; the ring counter clears to 0.
  - RINGING with `ack[i]` ends the ring.
  - RINGING with `tick` and ring counter = RING_TICKS-1 (RING_TICKS≠0) ends the ring. Otherwise `tick` increments the counter.
  - A ring end goes to ARMED if `repeat_md[i]`, else to DONE.
  - DONE holds until `arm[i]`=0.
- In RINGING, `en`, `rise` and prog changes are ignored. The ring completes regardless.
- On return to ARMED in repeat mode, no retrigger happens while the times stay equal, because `match_q` is still set.
- `ack` outside RINGING is ignored. Channels are fully independent.

## Timing
- Reset: all states are IDLE; `match_q`=0, ring counters 0, `fin`=0, `any_fin`=0, `armed`=0.
- Reset mid-ring drops `fin` after that edge.
- Match latency: equality present in cycle k causes `fin`=1 from the edge at the end of cycle k (1 cycle).
- `any_fin` follows `fin` on the same edge (it is computed from next-state).
- `ack` in cycle k gives `fin`=0 after that edge.
- Tick-terminated ring: `fin` is high until the edge that samples the RING_TICKS-th `tick` after entry. A `tick` in the entry cycle does not count.
- `ack` and the final `tick` in the same cycle count as one ring end.
- `arm` low in cycle k gives IDLE and `fin`=0 after that edge, overriding `ack` and `tick`.
- Raising `arm` on the cycle of a match gives IDLE→ARMED only. Triggering requires a later rise, i.e. the time must leave equality and return.

## Structure
- Package `timer_cmp_pkg`: state enum (`ST_IDLE`, `ST_ARMED`, `ST_RINGING`, `ST_DONE`), field slice helper constants, ring counter width = $clog2(RING_TICKS+1) with a minimum of 1.
- Sub-module `timer_cmp_ch`: one channel (comparator, `match_q`, FSM, ring counter). The top generates N_CH instances and the `any_fin` OR.

## Test plan
- Reset, arm ch0 with prog 12:30:05, then count steps 12:30:04 → 12:30:05 → `fin[0]`=1 one cycle later; after 10 ticks → 0; state DONE.
- Prog 00:00:00, armed, count 00:00:00 → `fin` never asserts.
- Ch1 `repeat_md`=1, RING_TICKS=3, count held at match → one ring of 3 ticks, returns to ARMED, no retrigger; count leaves and re-enters match → rings again.
- Ring in progress with `ack[0]` and `tick` in the same cycle → `fin[0]`=0 next cycle. Separately, `arm[0]` dropped mid-ring → IDLE, `fin[0]`=0 next cycle.
- `en`=0 while equal, then `en`=1 → trigger on the re-enable cycle. Both channels matching the same time → both `fin` bits and `any_fin` high together.
- Reset asserted during RINGING → all outputs 0 after that edge; no ring resumes after reset release.
